// File: rtl/vm3_mmu_ctl_if.sv
// Bus bundle for vm3_mmu_ctl: host register bus, W-bit requester, lookup port and RAM ports.
// slave = controller view, master = requester/RAM environment view.
interface vm3_mmu_ctl_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          busy;
  logic          host_req;
  logic          host_we;
  logic [1:0]    host_be;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_rdy;
  logic [DW-1:0] host_rdata;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic          wb_ack;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_vld;
  logic [DW-1:0] lk_data;
  logic [AW-1:0] ram_addr_a;
  logic          ram_wren_a;
  logic [1:0]    ram_be_a;
  logic [DW-1:0] ram_data_a;
  logic [DW-1:0] ram_q_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_wren_b;
  logic [DW-1:0] ram_q_b;

  modport slave (
    input  host_req, host_we, host_be, host_addr, host_wdata,
    input  wb_req, wb_addr, lk_req, lk_addr, ram_q_a, ram_q_b,
    output busy, host_ack, host_rdy, host_rdata, wb_ack, lk_vld, lk_data,
    output ram_addr_a, ram_wren_a, ram_be_a, ram_data_a, ram_addr_b, ram_wren_b
  );

  modport master (
    output host_req, host_we, host_be, host_addr, host_wdata,
    output wb_req, wb_addr, lk_req, lk_addr, ram_q_a, ram_q_b,
    input  busy, host_ack, host_rdy, host_rdata, wb_ack, lk_vld, lk_data,
    input  ram_addr_a, ram_wren_a, ram_be_a, ram_data_a, ram_addr_b, ram_wren_b
  );
endinterface

// File: rtl/vm3_mmu_ctl.sv
// vm3_mmu_ctl: access controller for the MMU PAR/PDR dual-port RAM (clear, port A arbitration, lookups).
// Define VM3_MMU_WBIT_EN to include the PDR W-bit read-modify-write requester.
module vm3_mmu_ctl #(
  parameter int AW = 5,
  parameter int DW = 16,
  parameter int WB = 6
) (
  input logic          clock,
  input logic          reset,
  vm3_mmu_ctl_if.slave bus
);

`ifdef VM3_MMU_WBIT_EN
  typedef enum logic [1:0] {ST_CLR = 2'd0, ST_RUN = 2'd1, ST_RMW = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_CLR = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  localparam logic [7:0] WB_MASK = 8'(1 << WB);

  state_t        state_r;
  logic [AW-1:0] cnt_r;
  logic          host_rdy_r;
  logic          host_rd_r;
  logic          lk_vld_r;
  logic          lk_pend_r;
  logic [AW-1:0] lk_pend_addr_r;

  logic          grant_host_s;
  logic [AW-1:0] addr_a_s;
  logic          wren_a_s;
  logic [1:0]    be_a_s;
  logic [DW-1:0] data_a_s;
  logic          wren_a_g_s;
  logic          lk_want_s;
  logic [AW-1:0] lk_addr_s;
  logic          lk_block_s;
  logic          lk_issue_s;

`ifdef VM3_MMU_WBIT_EN
  logic          rr_wb_last_r;
  logic          wb_ack_r;
  logic [AW-1:0] wb_addr_r;
  logic          grant_wb_s;

  function automatic logic [DW-1:0] set_wbit(input logic [DW-1:0] q);
    set_wbit = {q[DW-1:8], q[7:0] | WB_MASK};
  endfunction
`else
  logic          wb_unused_s;
  assign wb_unused_s = ^{bus.wb_req, bus.wb_addr, WB_MASK};
`endif

  // Port A source select: clear sweep, arbitrated host / W-bit read, or RMW write-back.
  always_comb begin
    grant_host_s = 1'b0;
`ifdef VM3_MMU_WBIT_EN
    grant_wb_s   = 1'b0;
`endif
    addr_a_s     = bus.host_addr;
    wren_a_s     = 1'b0;
    be_a_s       = 2'b00;
    data_a_s     = {DW{1'b0}};
    case (state_r)
      ST_CLR: begin
        addr_a_s = cnt_r;
        wren_a_s = 1'b1;
        be_a_s   = 2'b11;
      end
      ST_RUN: begin
`ifdef VM3_MMU_WBIT_EN
        // On contention the requester not served last wins.
        if (bus.wb_req && (!bus.host_req || !rr_wb_last_r)) begin
          grant_wb_s = 1'b1;
          addr_a_s   = bus.wb_addr;
        end else begin
          grant_host_s = bus.host_req;
        end
`else
        grant_host_s = bus.host_req;
`endif
        if (grant_host_s) begin
          wren_a_s = bus.host_we;
          be_a_s   = bus.host_be;
          data_a_s = bus.host_wdata;
        end else begin
          wren_a_s = 1'b0;
        end
      end
`ifdef VM3_MMU_WBIT_EN
      ST_RMW: begin
        addr_a_s = wb_addr_r;
        if (!bus.ram_q_a[WB]) begin
          wren_a_s = 1'b1;
          be_a_s   = 2'b01;
          data_a_s = set_wbit(bus.ram_q_a);
        end else begin
          wren_a_s = 1'b0;
        end
      end
`endif
      default: begin
        addr_a_s = bus.host_addr;
      end
    endcase
  end

  // A write in the reset cycle is dropped; a lookup hitting the port A write address waits a cycle.
  assign wren_a_g_s = wren_a_s & ~reset;
  assign lk_want_s  = lk_pend_r | bus.lk_req;
  assign lk_addr_s  = lk_pend_r ? lk_pend_addr_r : bus.lk_addr;
  assign lk_block_s = (state_r == ST_CLR) || (wren_a_g_s && (addr_a_s == lk_addr_s));
  assign lk_issue_s = lk_want_s & ~lk_block_s & ~reset;

  // Controller state machine with response pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_CLR;
      cnt_r          <= {AW{1'b0}};
      host_rdy_r     <= 1'b0;
      host_rd_r      <= 1'b0;
      lk_vld_r       <= 1'b0;
      lk_pend_r      <= 1'b0;
      lk_pend_addr_r <= {AW{1'b0}};
`ifdef VM3_MMU_WBIT_EN
      rr_wb_last_r   <= 1'b1;
      wb_ack_r       <= 1'b0;
      wb_addr_r      <= {AW{1'b0}};
`endif
    end else begin
      host_rdy_r     <= grant_host_s;
      host_rd_r      <= grant_host_s & ~bus.host_we;
      lk_vld_r       <= lk_issue_s;
      lk_pend_r      <= lk_want_s & lk_block_s;
      lk_pend_addr_r <= lk_addr_s;
`ifdef VM3_MMU_WBIT_EN
      wb_ack_r       <= grant_wb_s;
      if (grant_host_s) begin
        rr_wb_last_r <= 1'b0;
      end else if (grant_wb_s) begin
        rr_wb_last_r <= 1'b1;
        wb_addr_r    <= bus.wb_addr;
      end else begin
        rr_wb_last_r <= rr_wb_last_r;
      end
`endif
      case (state_r)
        ST_CLR: begin
          cnt_r <= cnt_r + AW'(1);
          if (&cnt_r) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
`ifdef VM3_MMU_WBIT_EN
          if (grant_wb_s) begin
            state_r <= ST_RMW;
          end
`else
          state_r <= ST_RUN;
`endif
        end
`ifdef VM3_MMU_WBIT_EN
        ST_RMW: begin
          state_r <= ST_RUN;
        end
`endif
        default: begin
          state_r <= ST_CLR;
        end
      endcase
    end
  end

  assign bus.busy       = (state_r == ST_CLR);
  assign bus.host_ack   = grant_host_s & ~reset;
  assign bus.host_rdy   = host_rdy_r;
  assign bus.host_rdata = (host_rdy_r && host_rd_r) ? bus.ram_q_a : {DW{1'b0}};
  assign bus.lk_vld     = lk_vld_r;
  assign bus.lk_data    = lk_vld_r ? bus.ram_q_b : {DW{1'b0}};
  assign bus.ram_addr_a = addr_a_s;
  assign bus.ram_wren_a = wren_a_g_s;
  assign bus.ram_be_a   = be_a_s;
  assign bus.ram_data_a = data_a_s;
  assign bus.ram_addr_b = lk_addr_s;
  assign bus.ram_wren_b = 1'b0;
`ifdef VM3_MMU_WBIT_EN
  assign bus.wb_ack     = wb_ack_r;
`else
  assign bus.wb_ack     = 1'b0;
`endif

endmodule
